// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_ctrl_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] NOP_INSTR_DEF = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_HOLD  = 2'd2,
      ST_DRAIN = 2'd3
   } fetch_state_e;

   function automatic logic [XLEN-1:0] pc_step(input logic [XLEN-1:0] pc_v,
                                               input logic [XLEN-1:0] incr_v);
      return pc_v + incr_v;
   endfunction

endpackage

// File: rtl/fetch_ctrl_skid.sv
// One-entry buffer parking a fetched instruction while ID is stalled.
module fetch_ctrl_skid
   import fetch_ctrl_pkg::*;
#(
   parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            load,
   input  logic            clear,
   input  logic            flush,
   input  logic [XLEN-1:0] load_instr,
   input  logic [XLEN-1:0] load_npc,
   output logic [XLEN-1:0] instr,
   output logic [XLEN-1:0] npc,
   output logic            full
);

   logic [XLEN-1:0] instr_r;
   logic [XLEN-1:0] npc_r;
   logic            full_r;

   // Skid entry register: emptied on consume or flush, filled on load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr_r <= NOP_INSTR;
         npc_r   <= 32'h0000_0000;
         full_r  <= 1'b0;
      end else if (clear || flush) begin
         instr_r <= NOP_INSTR;
         npc_r   <= 32'h0000_0000;
         full_r  <= 1'b0;
      end else if (load) begin
         instr_r <= load_instr;
         npc_r   <= load_npc;
         full_r  <= 1'b1;
      end
   end

   assign instr = instr_r;
   assign npc   = npc_r;
   assign full  = full_r;

endmodule

// File: rtl/fetch_ctrl.sv
// IF-stage sequencer: owns the PC, runs the imem req/ready handshake,
// and loads the IF/ID register with stall hold and redirect flush.
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
   parameter logic [XLEN-1:0] PC_INCR   = 32'd1,
   parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            ex_mem_pc_src,
   input  logic [XLEN-1:0] ex_mem_npc,
   input  logic            id_stall,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ready,
   input  logic [XLEN-1:0] imem_rdata,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] if_id_instruction,
   output logic [XLEN-1:0] if_id_npc,
   output logic            if_id_valid
);

   fetch_state_e    state_r, state_s;
   logic [XLEN-1:0] pc_r, pc_s, pc_inc_s;
   logic [XLEN-1:0] ifid_instr_r, ifid_instr_s;
   logic [XLEN-1:0] ifid_npc_r, ifid_npc_s;
   logic            ifid_valid_r, ifid_valid_s;
   logic            req_r;
   logic [XLEN-1:0] addr_r;
   logic            skid_load_s, skid_clear_s, skid_flush_s;
   logic [XLEN-1:0] skid_instr_s, skid_npc_s;
   logic            skid_full_s;

   assign pc_inc_s = pc_step(pc_r, PC_INCR);

   fetch_ctrl_skid #(.NOP_INSTR(NOP_INSTR)) u_skid (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (skid_load_s),
      .clear      (skid_clear_s),
      .flush      (skid_flush_s),
      .load_instr (imem_rdata),
      .load_npc   (pc_inc_s),
      .instr      (skid_instr_s),
      .npc        (skid_npc_s),
      .full       (skid_full_s)
   );

   // Next-state, next-PC and IF/ID update; a redirect overrides everything.
   always_comb begin
      state_s      = state_r;
      pc_s         = pc_r;
      ifid_instr_s = ifid_instr_r;
      ifid_npc_s   = ifid_npc_r;
      ifid_valid_s = ifid_valid_r;
      skid_load_s  = 1'b0;
      skid_clear_s = 1'b0;
      skid_flush_s = 1'b0;
      if (ex_mem_pc_src) begin
         pc_s         = ex_mem_npc;
         ifid_instr_s = NOP_INSTR;
         ifid_npc_s   = 32'h0000_0000;
         ifid_valid_s = 1'b0;
         skid_flush_s = 1'b1;
         case (state_r)
            ST_FETCH: state_s = imem_ready ? ST_FETCH : ST_DRAIN;
            ST_DRAIN: state_s = ST_DRAIN;
            default:  state_s = ST_FETCH;
         endcase
      end else begin
         case (state_r)
            ST_IDLE: state_s = ST_FETCH;
            ST_FETCH: begin
               if (imem_ready && !id_stall) begin
                  ifid_instr_s = imem_rdata;
                  ifid_npc_s   = pc_inc_s;
                  ifid_valid_s = 1'b1;
                  pc_s         = pc_inc_s;
               end else if (imem_ready) begin
                  skid_load_s = 1'b1;
                  pc_s        = pc_inc_s;
                  state_s     = ST_HOLD;
               end else if (!id_stall) begin
                  ifid_instr_s = NOP_INSTR;
                  ifid_npc_s   = 32'h0000_0000;
                  ifid_valid_s = 1'b0;
               end else begin
                  state_s = ST_FETCH;
               end
            end
            ST_HOLD: begin
               if (!id_stall) begin
                  ifid_instr_s = skid_instr_s;
                  ifid_npc_s   = skid_npc_s;
                  ifid_valid_s = skid_full_s;
                  skid_clear_s = 1'b1;
                  state_s      = ST_FETCH;
               end else begin
                  state_s = ST_HOLD;
               end
            end
            ST_DRAIN: begin
               ifid_instr_s = NOP_INSTR;
               ifid_npc_s   = 32'h0000_0000;
               ifid_valid_s = 1'b0;
               state_s      = imem_ready ? ST_FETCH : ST_DRAIN;
            end
            default: state_s = ST_IDLE;
         endcase
      end
   end

   // State, PC, IF/ID and registered memory-request outputs.
   // In DRAIN the address stays on the abandoned request until it retires.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= ST_IDLE;
         pc_r         <= RESET_PC;
         ifid_instr_r <= NOP_INSTR;
         ifid_npc_r   <= 32'h0000_0000;
         ifid_valid_r <= 1'b0;
         req_r        <= 1'b0;
         addr_r       <= RESET_PC;
      end else begin
         state_r      <= state_s;
         pc_r         <= pc_s;
         ifid_instr_r <= ifid_instr_s;
         ifid_npc_r   <= ifid_npc_s;
         ifid_valid_r <= ifid_valid_s;
         req_r        <= (state_s == ST_FETCH) || (state_s == ST_DRAIN);
         addr_r       <= (state_s == ST_DRAIN) ? addr_r : pc_s;
      end
   end

   assign imem_req          = req_r;
   assign imem_addr         = addr_r;
   assign pc                = pc_r;
   assign if_id_instruction = ifid_instr_r;
   assign if_id_npc         = ifid_npc_r;
   assign if_id_valid       = ifid_valid_r;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: variable-latency memory model plus an in-order
// scoreboard of instructions expected to reach ID.
module tb_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ex_mem_pc_src;
   logic [31:0] ex_mem_npc;
   logic        id_stall;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] pc;
   logic [31:0] if_id_instruction;
   logic [31:0] if_id_npc;
   logic        if_id_valid;

   fetch_ctrl dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .ex_mem_pc_src     (ex_mem_pc_src),
      .ex_mem_npc        (ex_mem_npc),
      .id_stall          (id_stall),
      .imem_req          (imem_req),
      .imem_addr         (imem_addr),
      .imem_ready        (imem_ready),
      .imem_rdata        (imem_rdata),
      .pc                (pc),
      .if_id_instruction (if_id_instruction),
      .if_id_npc         (if_id_npc),
      .if_id_valid       (if_id_valid)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] npc;
   } exp_t;

   exp_t        sb_q[$];
   int          checks_n = 0;
   int          fails_n  = 0;
   int          lat      = 1;
   bit          mem_busy = 1'b0;
   int          mem_cnt  = 0;
   logic [31:0] mem_addr_v = 32'h0;
   logic [31:0] exp_pc   = 32'h0;
   bit          stall_v  = 1'b0;
   bit          redir_v  = 1'b0;
   logic [31:0] tgt_v    = 32'h0;
   logic [31:0] a_v, p_v, frz_i, frz_n;

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
   endfunction

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks_n++;
      if (obs !== exp_v) begin
         fails_n++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
      end
   endtask

   // One clock: sample at negedge, run memory model, drive inputs, score.
   task automatic cycle();
      bit   rdy;
      exp_t e;
      @(negedge clk);
      if (!if_id_valid) check_val("bubble_nop", if_id_instruction, 32'h0);
      rdy = 1'b0;
      if (imem_req) begin
         if (!mem_busy) begin
            mem_busy   = 1'b1;
            mem_addr_v = imem_addr;
            mem_cnt    = 0;
         end else begin
            check_val("addr_stable", imem_addr, mem_addr_v);
         end
         if (mem_cnt >= lat - 1) begin
            rdy      = 1'b1;
            mem_busy = 1'b0;
         end else begin
            mem_cnt++;
         end
      end
      imem_ready    = rdy;
      imem_rdata    = rdy ? mem_data(mem_addr_v) : 32'hDEAD_BEEF;
      id_stall      = stall_v;
      ex_mem_pc_src = redir_v;
      ex_mem_npc    = tgt_v;
      if (if_id_valid && !stall_v) begin
         check_val("sb_nonempty", {31'd0, sb_q.size() != 0}, 32'd1);
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check_val("sb_instr", if_id_instruction, e.instr);
            check_val("sb_npc", if_id_npc, e.npc);
         end
      end
      if (redir_v) begin
         sb_q.delete();
         exp_pc = tgt_v;
      end else if (rdy && mem_addr_v == exp_pc) begin
         e.instr = mem_data(mem_addr_v);
         e.npc   = mem_addr_v + 32'd1;
         sb_q.push_back(e);
         exp_pc = exp_pc + 32'd1;
      end
   endtask

   initial begin
      rst_n = 1'b1; id_stall = 1'b0; ex_mem_pc_src = 1'b0; ex_mem_npc = 32'h0;
      imem_ready = 1'b0; imem_rdata = 32'h0;
      #2 rst_n = 1'b0;
      #1;
      check_val("rst_pc", pc, 32'h0);
      check_val("rst_req", {31'd0, imem_req}, 32'd0);
      check_val("rst_instr", if_id_instruction, 32'h0);
      check_val("rst_npc", if_id_npc, 32'h0);
      check_val("rst_valid", {31'd0, if_id_valid}, 32'd0);
      cycle(); cycle();
      rst_n = 1'b1;

      // Streaming with ready held high
      for (int k = 0; k <= 8; k++) begin
         cycle();
         check_val("t1_pc", pc, k);
         check_val("t1_req", {31'd0, imem_req}, 32'd1);
         if (k >= 1) begin
            check_val("t1_valid", {31'd0, if_id_valid}, 32'd1);
            check_val("t1_npc", if_id_npc, k);
         end
      end

      // Latency 3
      lat = 3;
      cycle(); a_v = imem_addr;
      check_val("t2_addr0", a_v, pc);
      for (int k = 0; k < 2; k++) begin
         cycle();
         check_val("t2_req", {31'd0, imem_req}, 32'd1);
         check_val("t2_addr", imem_addr, a_v);
         check_val("t2_bubble_v", {31'd0, if_id_valid}, 32'd0);
         check_val("t2_bubble_i", if_id_instruction, 32'h0);
      end
      lat = 1;
      cycle();
      check_val("t2_valid", {31'd0, if_id_valid}, 32'd1);
      check_val("t2_npc", if_id_npc, a_v + 32'd1);
      check_val("t2_instr", if_id_instruction, mem_data(a_v));

      // Stall raised on a ready cycle, held 4 cycles
      stall_v = 1'b1;
      cycle(); p_v = pc; frz_i = if_id_instruction; frz_n = if_id_npc;
      for (int k = 0; k < 4; k++) begin
         if (k == 3) stall_v = 1'b0;
         cycle();
         check_val("t3_req", {31'd0, imem_req}, 32'd0);
         check_val("t3_frz_i", if_id_instruction, frz_i);
         check_val("t3_frz_n", if_id_npc, frz_n);
      end
      cycle();
      check_val("t3_rel_valid", {31'd0, if_id_valid}, 32'd1);
      check_val("t3_rel_npc", if_id_npc, p_v + 32'd1);
      check_val("t3_rel_instr", if_id_instruction, mem_data(p_v));
      check_val("t3_next_addr", imem_addr, p_v + 32'd1);

      // Redirect during a pending latency-2 request
      lat = 2; redir_v = 1'b1; tgt_v = 32'h40;
      cycle(); a_v = imem_addr;
      redir_v = 1'b0;
      cycle();
      check_val("t4_drain_addr", imem_addr, a_v);
      check_val("t4_drain_req", {31'd0, imem_req}, 32'd1);
      check_val("t4_pc", pc, 32'h40);
      check_val("t4_valid0", {31'd0, if_id_valid}, 32'd0);
      cycle();
      check_val("t4_addr40", imem_addr, 32'h40);
      check_val("t4_valid1", {31'd0, if_id_valid}, 32'd0);
      cycle();
      check_val("t4_valid2", {31'd0, if_id_valid}, 32'd0);
      cycle();
      check_val("t4_valid", {31'd0, if_id_valid}, 32'd1);
      check_val("t4_npc", if_id_npc, 32'h41);
      check_val("t4_instr", if_id_instruction, mem_data(32'h40));

      // Redirect together with stall while in HOLD
      lat = 1; stall_v = 1'b1;
      cycle(); cycle();
      check_val("t5_hold_req", {31'd0, imem_req}, 32'd0);
      redir_v = 1'b1; tgt_v = 32'h80;
      cycle();
      redir_v = 1'b0; stall_v = 1'b0;
      cycle();
      check_val("t5_valid0", {31'd0, if_id_valid}, 32'd0);
      check_val("t5_pc", pc, 32'h80);
      check_val("t5_addr", imem_addr, 32'h80);
      cycle();
      check_val("t5_valid", {31'd0, if_id_valid}, 32'd1);
      check_val("t5_npc", if_id_npc, 32'h81);

      // Redirect with a ready response, to the wrap-around PC
      redir_v = 1'b1; tgt_v = 32'hFFFF_FFFF;
      cycle();
      redir_v = 1'b0;
      cycle();
      check_val("tw_valid0", {31'd0, if_id_valid}, 32'd0);
      check_val("tw_addr", imem_addr, 32'hFFFF_FFFF);
      cycle();
      check_val("tw_valid", {31'd0, if_id_valid}, 32'd1);
      check_val("tw_npc", if_id_npc, 32'h0);
      check_val("tw_pc", pc, 32'h0);
      cycle(); cycle();
      check_val("t6_pre_pc", pc, 32'h2);

      // Asynchronous reset between edges
      #2 rst_n = 1'b0;
      #1;
      mem_busy = 1'b0; sb_q.delete(); exp_pc = 32'h0;
      check_val("t6_pc", pc, 32'h0);
      check_val("t6_req", {31'd0, imem_req}, 32'd0);
      check_val("t6_valid", {31'd0, if_id_valid}, 32'd0);
      check_val("t6_npc", if_id_npc, 32'h0);
      cycle();
      check_val("t6_req_hold", {31'd0, imem_req}, 32'd0);
      #2 rst_n = 1'b1;
      #1;
      check_val("t6_rel_pc", pc, 32'h0);
      check_val("t6_rel_req", {31'd0, imem_req}, 32'd0);
      cycle();
      check_val("t6_first_req", {31'd0, imem_req}, 32'd1);
      check_val("t6_first_pc", pc, 32'h0);
      cycle(); cycle();
      check_val("t6_pc2", pc, 32'h2);

      lat = 1000;
      cycle(); cycle();
      check_val("sb_drained", sb_q.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks_n, fails_n);
      $finish;
   end

endmodule
